// File: rtl/jk_sched_pkg.sv
// Shared types and opcode constants for the JK bank scheduler.
package jk_sched_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_HOLD = 2'b00;
  localparam op_t OP_CLR  = 2'b01;
  localparam op_t OP_SET  = 2'b10;
  localparam op_t OP_TGL  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops with synchronous active-high clear.
module jk_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  // Characteristic equation q+ = j & ~q | ~k & q, applied per bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler serialising JK operations from NREQ requesters
// onto one shared JK flip-flop bank.
module jk_bank_sched
  import jk_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] mask,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      q,
  output state_t                state_dbg,
  output logic [PW-1:0]         ptr_dbg
);

  // Handshake: req is sampled only in IDLE; the winner sees a one-cycle
  // gnt pulse during APPLY and drops req in that cycle. op/mask are
  // captured in the winning IDLE cycle and ignored afterwards.

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [NREQ-1:0]  gnt_n;
  op_t              lat_op, op_n;
  logic [WIDTH-1:0] lat_mask, mask_n;
  logic [PW-1:0]    win;
  logic             found;
  int               idx;
  logic [WIDTH-1:0] j, k;

  // Search starts at ptr and wraps modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int n = 0; n < NREQ; n++) begin
      idx = (int'(ptr) + n) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = '0;
    op_n    = lat_op;
    mask_n  = lat_mask;
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = APPLY;
          gnt_n[win] = 1'b1;
          ptr_n      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          op_n       = op[2*int'(win) +: 2];
          mask_n     = mask[WIDTH*int'(win) +: WIDTH];
        end
      end
      APPLY:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      lat_op   <= OP_HOLD;
      lat_mask <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      gnt      <= gnt_n;
      lat_op   <= op_n;
      lat_mask <= mask_n;
    end
  end

  assign busy = (state == APPLY);
  // The bank only sees a non-hold J/K pair during APPLY.
  assign j    = busy ? ({WIDTH{lat_op[1]}} & lat_mask) : '0;
  assign k    = busy ? ({WIDTH{lat_op[0]}} & lat_mask) : '0;

  jk_bank #(.WIDTH(WIDTH)) u_bank (
    .clk   (clk),
    .reset (reset),
    .j     (j),
    .k     (k),
    .q     (q)
  );

  assign state_dbg = state;
  assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: transaction-level reference model feeding a
// scoreboard, with directed scenarios followed by random traffic.
module tb_jk_bank_sched;
  import jk_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int PW    = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_v;
  logic [2*NREQ-1:0]     op_v;
  logic [WIDTH*NREQ-1:0] mask_v;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      q;
  state_t                state_dbg;
  logic [PW-1:0]         ptr_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int               m_ptr;
  logic [WIDTH-1:0] m_q;
  bit               m_busy;
  logic [NREQ-1:0]  exp_gnt_q[$];
  logic [WIDTH-1:0] exp_q[$];

  jk_bank_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req_v),
    .op        (op_v),
    .mask      (mask_v),
    .gnt       (gnt),
    .busy      (busy),
    .q         (q),
    .state_dbg (state_dbg),
    .ptr_dbg   (ptr_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
    checks++;
    if (act !== req_val) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_val, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Decides what the coming posedge does, from the inputs about to be sampled.
  task automatic model_step();
    int win;
    op_t o;
    logic [WIDTH-1:0] m;
    if (reset) begin
      m_ptr  = 0;
      m_q    = '0;
      m_busy = 0;
      exp_gnt_q.delete();
      exp_q.delete();
    end else if (m_busy) begin
      m_busy = 0;
    end else if (req_v != '0) begin
      win = -1;
      for (int n = 0; n < NREQ; n++) begin
        if (win < 0 && req_v[(m_ptr + n) % NREQ]) win = (m_ptr + n) % NREQ;
      end
      o = op_v[2*win +: 2];
      m = mask_v[WIDTH*win +: WIDTH];
      case (o)
        OP_CLR:  m_q = m_q & ~m;
        OP_SET:  m_q = m_q | m;
        OP_TGL:  m_q = m_q ^ m;
        default: m_q = m_q;
      endcase
      exp_gnt_q.push_back(NREQ'(1) << win);
      exp_q.push_back(m_q);
      m_ptr  = (win + 1) % NREQ;
      m_busy = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    model_step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i] === 1'b1) begin
        req_v[i] = 1'b0;
        op_v[2*i +: 2]         = 2'($urandom_range(0, 3));
        mask_v[WIDTH*i +: WIDTH] = WIDTH'($urandom);
      end
    end
  endtask

  task automatic issue(input int i, input op_t o, input logic [WIDTH-1:0] m);
    req_v[i]                 = 1'b1;
    op_v[2*i +: 2]           = o;
    mask_v[WIDTH*i +: WIDTH] = m;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((req_v != '0 || m_busy || exp_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_drain actual=timeout required=idle", name);
    end
  endtask

  task automatic expect_q(input string name, input logic [WIDTH-1:0] v);
    check(name, 32'(q), 32'(v));
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [WIDTH-1:0] q_exp;
  logic [WIDTH-1:0] last_q = '0;
  bit               q_due  = 0;

  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_q", 32'(q), 32'h0);
      check("reset_state", 32'(state_dbg), 32'(IDLE));
      check("reset_ptr", 32'(ptr_dbg), 32'h0);
      q_due  = 0;
      last_q = '0;
    end else begin
      if (q_due) begin
        check("q_after_apply", 32'(q), 32'(q_exp));
        last_q = q_exp;
        q_due  = 0;
      end else begin
        check("q_stable", 32'(q), 32'(last_q));
      end
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) begin
          check("unexpected_gnt", 32'(gnt), 32'h0);
        end else begin
          check("gnt", 32'(gnt), 32'(exp_gnt_q.pop_front()));
          q_exp = exp_q.pop_front();
          q_due = 1;
        end
        check("busy_in_apply", 32'(busy), 32'h1);
      end else begin
        if (exp_gnt_q.size() != 0) check("missing_gnt", 32'(gnt), 32'(exp_gnt_q[0]));
        check("busy_idle", 32'(busy), 32'h0);
      end
      check("ptr", 32'(ptr_dbg), 32'(m_ptr));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    req_v  = NREQ'($urandom);
    op_v   = (2*NREQ)'($urandom);
    mask_v = (WIDTH*NREQ)'($urandom);
    m_ptr  = 0;
    m_q    = '0;
    m_busy = 0;
    tick();
    tick();
    reset = 1'b0;
    req_v = '0;
    tick();
    tick();

    // Single SET from requester 0.
    issue(0, OP_SET, 8'h0F);
    drain("single_set");
    expect_q("single_set_q", 8'h0F);
    check("single_set_ptr", 32'(ptr_dbg), 32'h1);

    // Contention from ptr=0, all TGL.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    issue(0, OP_TGL, 8'h01);
    issue(1, OP_TGL, 8'h02);
    issue(2, OP_TGL, 8'h04);
    issue(3, OP_TGL, 8'h08);
    drain("contention");
    expect_q("contention_q", 8'h0F);
    issue(0, OP_TGL, 8'h01);
    drain("contention_wrap");
    expect_q("contention_wrap_q", 8'h0E);

    // Walk ptr to 3, then 0 and 3 together.
    issue(1, OP_HOLD, 8'hFF);
    drain("walk1");
    issue(2, OP_HOLD, 8'hFF);
    drain("walk2");
    check("walk_ptr", 32'(ptr_dbg), 32'h3);
    issue(0, OP_HOLD, 8'h00);
    issue(3, OP_HOLD, 8'h00);
    drain("wrap");
    check("wrap_ptr", 32'(ptr_dbg), 32'h1);

    // CLR / TGL / HOLD / zero mask against q=F0.
    issue(1, OP_CLR, 8'hFF);
    drain("clr_all");
    issue(2, OP_SET, 8'hF0);
    drain("set_f0");
    expect_q("set_f0_q", 8'hF0);
    issue(3, OP_CLR, 8'h3C);
    drain("clr");
    expect_q("clr_q", 8'hC0);
    issue(0, OP_SET, 8'h30);
    drain("restore1");
    issue(1, OP_TGL, 8'h3C);
    drain("tgl");
    expect_q("tgl_q", 8'hCC);
    issue(2, OP_CLR, 8'h0C);
    drain("restore2a");
    issue(3, OP_SET, 8'h30);
    drain("restore2b");
    issue(0, OP_HOLD, 8'h3C);
    drain("hold");
    expect_q("hold_q", 8'hF0);
    issue(1, OP_TGL, 8'h00);
    drain("mask0");
    expect_q("mask0_q", 8'hF0);

    // Reset during APPLY of SET FF.
    issue(2, OP_SET, 8'hFF);
    tick();
    check("midop_in_apply", 32'(state_dbg), 32'(APPLY));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("midop_state", 32'(state_dbg), 32'(IDLE));
    expect_q("midop_q", 8'h00);
    tick();

    // Random traffic.
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v[i] && $urandom_range(0, 2) == 0)
          issue(i, 2'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0) ? 8'h00 : WIDTH'($urandom));
      end
      tick();
    end
    drain("random");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
